// File: rtl/vbank_stream_reader.sv
// Strided multi-row read initiator for one vbank: issues ren/raddr, absorbs the 1-cycle read
// latency through a 2-entry FIFO and streams rows out on valid/ready. Optional mask: VBANK_RD_MASK_EN.
module vbank_stream_reader #(
  parameter int INDEX_WIDTH  = 8,
  parameter int NUM_ELEMENTS = 32,
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_LEN      = 32,
  parameter int LEN_W        = $clog2(MAX_LEN + 1)
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [INDEX_WIDTH-1:0]             req_base,
  input  logic [INDEX_WIDTH-1:0]             req_stride,
  input  logic [LEN_W-1:0]                   req_len,
`ifdef VBANK_RD_MASK_EN
  input  logic [NUM_ELEMENTS-1:0]            req_emask,
`endif
  output logic                               bank_ren,
  output logic [INDEX_WIDTH-1:0]             bank_raddr,
  input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0] bank_rdata,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH*NUM_ELEMENTS-1:0] out_data,
  output logic [LEN_W-1:0]                   out_idx,
  output logic                               out_last,
  output logic                               busy
);

  localparam int ROW_W = DATA_WIDTH * NUM_ELEMENTS;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                 state, state_next;
  logic [INDEX_WIDTH-1:0] addr_q, stride_q;
  logic [LEN_W-1:0]       len_q, k_q, eff_len;
  logic                   inflight, infl_last;
  logic [LEN_W-1:0]       infl_idx;
`ifdef VBANK_RD_MASK_EN
  logic [NUM_ELEMENTS-1:0] emask_q;
`endif

  logic [ROW_W-1:0] fifo_data [2];
  logic [LEN_W-1:0] fifo_idx  [2];
  logic             fifo_last [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       fifo_count;

  logic       pop, push, issue, last_issue, start, drain_done;
  logic [2:0] occ_after_pop;
  logic [ROW_W-1:0] head;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    eff_len       = (req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len;
    out_valid     = (fifo_count != 2'd0);
    pop           = out_valid && out_ready;
    push          = inflight;
    // Reads still owed a FIFO slot once this cycle's pop is accounted for.
    occ_after_pop = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    issue         = (state == ISSUE) && (occ_after_pop < 3'd2);
    last_issue    = (k_q == len_q - LEN_W'(1));
    // Exit DRAIN so that IDLE lands in the cycle right after the final pop.
    drain_done    = !inflight && (fifo_count == {1'b0, pop});
    start         = 1'b0;
    state_next    = state;
    case (state)
      IDLE: begin
        if (req_valid && eff_len != '0) begin
          start      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:   if (issue && last_issue) state_next = DRAIN;
      DRAIN:   if (drain_done)          state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign bank_ren   = issue;
  assign bank_raddr = addr_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      stride_q  <= '0;
      len_q     <= '0;
      k_q       <= '0;
      inflight  <= 1'b0;
      infl_idx  <= '0;
      infl_last <= 1'b0;
`ifdef VBANK_RD_MASK_EN
      emask_q   <= '0;
`endif
    end else begin
      state     <= state_next;
      inflight  <= issue;
      infl_idx  <= k_q;
      infl_last <= last_issue;
      if (start) begin
        addr_q   <= req_base;
        stride_q <= req_stride;
        len_q    <= eff_len;
        k_q      <= '0;
`ifdef VBANK_RD_MASK_EN
        emask_q  <= req_emask;
`endif
      end else if (issue) begin
        addr_q <= addr_q + stride_q;
        k_q    <= k_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the outputs are gated by out_valid, so stale slots never leak.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bank_rdata;
      fifo_idx[wr_ptr]  <= infl_idx;
      fifo_last[wr_ptr] <= infl_last;
    end
  end

  always_comb begin
    head     = fifo_data[rd_ptr];
    out_data = '0;
    out_idx  = '0;
    out_last = 1'b0;
    if (out_valid) begin
`ifdef VBANK_RD_MASK_EN
      for (int i = 0; i < NUM_ELEMENTS; i++)
        out_data[i*DATA_WIDTH +: DATA_WIDTH] = emask_q[i] ? head[i*DATA_WIDTH +: DATA_WIDTH] : '0;
`else
      out_data = head;
`endif
      out_idx  = fifo_idx[rd_ptr];
      out_last = fifo_last[rd_ptr];
    end
  end

endmodule

// File: tb/tb_vbank_stream_reader.sv
// Self-checking bench for vbank_stream_reader: behavioural bank + expected beat list derived from
// base/stride/len arithmetic, with directed and randomized requests.
module tb_vbank_stream_reader;
  localparam int IW = 8;
  localparam int NE = 32;
  localparam int DW = 16;
  localparam int ML = 32;
  localparam int LW = $clog2(ML + 1);
  localparam int RW = DW * NE;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_base, req_stride;
  logic [LW-1:0] req_len;
`ifdef VBANK_RD_MASK_EN
  logic [NE-1:0] emask = '1;
`endif
  logic          bank_ren;
  logic [IW-1:0] bank_raddr;
  logic [RW-1:0] bank_rdata;
  logic          out_valid, out_ready;
  logic [RW-1:0] out_data;
  logic [LW-1:0] out_idx;
  logic          out_last, busy;

  vbank_stream_reader #(.INDEX_WIDTH(IW), .NUM_ELEMENTS(NE), .DATA_WIDTH(DW), .MAX_LEN(ML)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_stride(req_stride), .req_len(req_len),
`ifdef VBANK_RD_MASK_EN
    .req_emask(emask),
`endif
    .bank_ren(bank_ren), .bank_raddr(bank_raddr), .bank_rdata(bank_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [RW-1:0] mem [256];
  always @(posedge clk) if (bank_ren) bank_rdata <= mem[bank_raddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [RW-1:0] data; logic [LW-1:0] idx; logic last; int cyc; } beat_t;
  typedef struct { logic [IW-1:0] addr; int cyc; } rd_t;
  beat_t beats[$];
  rd_t   rds[$];
  int    rise_cyc = -1;
  logic  prev_ready = 1'b1;

  always @(negedge clk) begin
    beat_t b;
    rd_t   r;
    if (n_rst && out_valid && out_ready) begin
      b.data = out_data; b.idx = out_idx; b.last = out_last; b.cyc = cyc;
      beats.push_back(b);
    end
    if (n_rst && bank_ren) begin
      r.addr = bank_raddr; r.cyc = cyc;
      rds.push_back(r);
    end
    if (req_ready && !prev_ready) rise_cyc = cyc;
    prev_ready = req_ready;
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] exp_row(input int addr);
    logic [RW-1:0] r;
    r = mem[addr % 256];
`ifdef VBANK_RD_MASK_EN
    for (int e = 0; e < NE; e++) if (!emask[e]) r[e*DW +: DW] = '0;
`endif
    return r;
  endfunction

  task automatic check_reset_outs(input string p);
    check({p, "_req_ready"}, req_ready, 1);
    check({p, "_bank_ren"},  bank_ren, 0);
    check({p, "_raddr"},     bank_raddr, 0);
    check({p, "_out_valid"}, out_valid, 0);
    check({p, "_out_data"},  out_data, 0);
    check({p, "_out_idx"},   out_idx, 0);
    check({p, "_out_last"},  out_last, 0);
    check({p, "_busy"},      busy, 0);
  endtask

  // Called at posedge+1; the request is presented for exactly one cycle.
  task automatic send(input int base, input int stride, input int len, output int acc);
    beats.delete();
    rds.delete();
    req_valid  = 1'b1;
    req_base   = IW'(base);
    req_stride = IW'(stride);
    req_len    = LW'(len);
    acc        = cyc;
    @(posedge clk); #1;
    req_valid  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int n, input bit rnd);
    int c;
    c = 0;
    while (int'(beats.size()) < n && c < 2000) begin
      @(posedge clk); #1;
      c++;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    end
    out_ready = 1'b1;
    c = 0;
    while (busy && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check({name, "_idle"}, busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic verify(input string name, input int base, input int stride, input int len,
                        input int acc, input bit timed);
    int n, a;
    n = (len > ML) ? ML : len;
    check({name, "_nbeats"}, beats.size(), n);
    check({name, "_nreads"}, rds.size(), n);
    for (int i = 0; i < n; i++) begin
      a = (base + i * stride) % 256;
      if (i < rds.size()) begin
        check($sformatf("%s_raddr%0d", name, i), rds[i].addr, a);
        if (timed) check($sformatf("%s_rcyc%0d", name, i), rds[i].cyc, acc + 1 + i);
      end
      if (i < beats.size()) begin
        check($sformatf("%s_data%0d", name, i), beats[i].data, exp_row(a));
        check($sformatf("%s_idx%0d", name, i), beats[i].idx, i);
        check($sformatf("%s_last%0d", name, i), beats[i].last, (i == n - 1));
        if (timed) check($sformatf("%s_bcyc%0d", name, i), beats[i].cyc, acc + 3 + i);
      end
    end
  endtask

  initial begin
    int acc, c, b, s, l;
    n_rst = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    req_base = '0; req_stride = '0; req_len = '0;
    for (int r = 0; r < 256; r++)
      for (int e = 0; e < NE; e++)
        mem[r][e*DW +: DW] = (r >= 4 && r <= 7) ? 16'(r * 16'h0101) : 16'($urandom);

    #3;
    check_reset_outs("rst");
    repeat (2) @(posedge clk);
    #1; n_rst = 1'b1;
    @(posedge clk); #1;

    // Basic back-to-back stream with latency and req_ready return timing.
    send(4, 1, 4, acc);
    wait_done("basic", 4, 0);
    verify("basic", 4, 1, 4, acc, 1);
    check("basic_pattern", (beats.size() > 0) ? beats[0].data[DW-1:0] : '1, 16'h0404);
    check("basic_ready_rise", rise_cyc, (beats.size() > 0) ? beats[beats.size()-1].cyc + 1 : -1);

    // Address wrap with stride.
    send(250, 3, 4, acc);
    wait_done("wrap", 4, 0);
    verify("wrap", 250, 3, 4, acc, 1);

    // Backpressure: consumer stalled from the start, beat 0 must hold.
    out_ready = 1'b0;
    send(16, 2, 8, acc);
    c = 0;
    while (!out_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("bp_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_data%0d", i), out_data, exp_row(16));
      check($sformatf("bp_hold_idx%0d", i), out_idx, 0);
    end
    check("bp_reads_stalled", rds.size(), 2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done("bp", 8, 0);
    verify("bp", 16, 2, 8, acc, 0);

    // Zero length followed immediately by a length-1 request.
    send(9, 1, 0, acc);
    check("len0_ready", req_ready, 1);
    check("len0_ren", bank_ren, 0);
    send(9, 5, 1, acc);
    wait_done("len1", 1, 0);
    verify("len1", 9, 5, 1, acc, 1);

    // Oversized length clamps to MAX_LEN.
    send(0, 7, ML + 5, acc);
    wait_done("over", ML, 0);
    verify("over", 0, 7, ML + 5, acc, 1);

    // Randomized requests with random consumer stalls.
    for (int t = 0; t < 6; t++) begin
      b = $urandom_range(0, 255);
      s = $urandom_range(0, 255);
      l = $urandom_range(1, 12);
      send(b, s, l, acc);
      wait_done($sformatf("rnd%0d", t), l, 1);
      verify($sformatf("rnd%0d", t), b, s, l, acc, 0);
    end

    // Reset in the middle of ISSUE.
    send(100, 1, 8, acc);
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    check_reset_outs("midrst");
    repeat (2) @(posedge clk);
    #1; n_rst = 1'b1;
    beats.delete();
    rds.delete();
    repeat (5) @(posedge clk);
    #1;
    check("midrst_nobeats", beats.size(), 0);
    check("midrst_noreads", rds.size(), 0);
    send(40, 2, 2, acc);
    wait_done("post", 2, 0);
    verify("post", 40, 2, 2, acc, 1);

`ifdef VBANK_RD_MASK_EN
    emask = 32'h0000_000F;
    send(200, 1, 4, acc);
    wait_done("mask", 4, 0);
    verify("mask", 200, 1, 4, acc, 1);
    emask = '1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
